mini_alu: RTL and testbench

Minimal two-stage processor core that runs a fixed program from an internal instruction ROM and drives an 8-bit LED bank. It is the top-level demonstration block for the board: one clock, one reset, LEDs out.
- Internal contents: program counter, instruction register, 16-entry register file and a 16-bit ALU.
- No external data or instruction bus.

---
 rtl/mini_alu_pkg.sv | 39 +++
 rtl/mini_alu_if.sv | 16 +
 rtl/mini_alu_rom.sv | 37 +++
 rtl/mini_alu.sv | 123 ++++++++++++
 tb/tb_mini_alu.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg
// Shared constants for the mini_alu core: instruction layout, opcode values,
// datapath width and a helper that assembles instruction words.
package mini_alu_pkg;

    localparam int INSTR_W   = 28;
    localparam int DATA_W    = 16;
    localparam int REG_N     = 16;
    localparam int REG_SEL_W = 4;
    localparam int ALT_WORDS = 16;

    // Instruction field positions
    localparam int OP_LSB   = 24;
    localparam int OP_W     = 4;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC0_LSB = 0;
    localparam int FIELD_W  = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LED = 4'd1,
        OP_STO = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_BLE = 4'd5,
        OP_JMP = 4'd6
    } opcode_e;

    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

    function automatic logic [INSTR_W-1:0] mk_instr(input opcode_e op,
                                                    input logic [7:0] dst,
                                                    input logic [7:0] src1,
                                                    input logic [7:0] src0);
        return {op, dst, src1, src0};
    endfunction

endpackage

// File: rtl/mini_alu_if.sv
// mini_alu_if
// Observation bundle exposing the fetch-stage state of the core.
//   pc : program counter (address of the next fetch)
//   ir : instruction register (instruction in the execute stage)
// master = core side (drives), slave = observer side.
interface mini_alu_if
    import mini_alu_pkg::*;
#(
    parameter int PC_W = 8
) ();
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;

    modport master (output pc, ir);
    modport slave  (input  pc, ir);
endinterface

// File: rtl/mini_alu_rom.sv
// mini_alu_rom
// Combinational instruction ROM. Holds the board demo program unless an
// alternate 16-word program is supplied; every unpopulated address reads NOP.
//   i_addr  : fetch address
//   o_instr : instruction word at i_addr
module mini_alu_rom
    import mini_alu_pkg::*;
#(
    parameter int                           ROM_DEPTH    = 256,
    parameter bit                           USE_ALT_PROG = 1'b0,
    parameter logic [ALT_WORDS*INSTR_W-1:0] ALT_PROG     = '0,
    localparam int                          ADDR_W       = $clog2(ROM_DEPTH)
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [INSTR_W-1:0] o_instr
);

    always_comb begin
        o_instr = INSTR_NOP;
        if (USE_ALT_PROG) begin
            if (int'(i_addr) < ALT_WORDS) begin
                o_instr = ALT_PROG[int'(i_addr)*INSTR_W +: INSTR_W];
            end
        end else begin
            case (i_addr)
                ADDR_W'(0): o_instr = INSTR_NOP;
                ADDR_W'(1): o_instr = mk_instr(OP_STO, 8'd1, 8'h00, 8'h01);
                ADDR_W'(2): o_instr = mk_instr(OP_STO, 8'd2, 8'h00, 8'h00);
                ADDR_W'(3): o_instr = mk_instr(OP_ADD, 8'd2, 8'd2, 8'd1);
                ADDR_W'(4): o_instr = mk_instr(OP_LED, 8'd0, 8'd2, 8'd0);
                ADDR_W'(5): o_instr = mk_instr(OP_JMP, 8'd3, 8'd0, 8'd0);
                default:    o_instr = INSTR_NOP;
            endcase
        end
    end

endmodule

// File: rtl/mini_alu.sv
// mini_alu
// Two-stage demo core: fetch (PC -> IR) and execute (decode IR, ALU,
// register-file write, LED update, branch). Runs the program held in
// mini_alu_rom and drives an 8-bit LED bank.
//   Clock : system clock, rising edge
//   Reset : synchronous, active high
//   oLed  : registered LED bank
//   dbg   : PC / IR observation
module mini_alu
    import mini_alu_pkg::*;
#(
    parameter int                           ROM_DEPTH    = 256,
    parameter int                           DATA_W       = mini_alu_pkg::DATA_W,
    parameter bit                           USE_ALT_PROG = 1'b0,
    parameter logic [ALT_WORDS*INSTR_W-1:0] ALT_PROG     = '0,
    localparam int                          PC_W         = $clog2(ROM_DEPTH)
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [7:0] oLed,
    mini_alu_if.master dbg
);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [7:0]         r_led;
    logic [DATA_W-1:0]  r_regs [REG_N];

    logic [INSTR_W-1:0]   w_rom_data;
    logic [PC_W-1:0]      w_pc_inc;
    logic [3:0]           w_op;
    logic [7:0]           w_dst;
    logic [7:0]           w_src1;
    logic [7:0]           w_src0;
    logic [REG_SEL_W-1:0] w_dst_sel;
    logic [REG_SEL_W-1:0] w_s1_sel;
    logic [REG_SEL_W-1:0] w_s0_sel;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_we;
    logic                 w_led_we;
    logic                 w_take;

    mini_alu_rom #(
        .ROM_DEPTH    (ROM_DEPTH),
        .USE_ALT_PROG (USE_ALT_PROG),
        .ALT_PROG     (ALT_PROG)
    ) u_rom (
        .i_addr  (r_pc),
        .o_instr (w_rom_data)
    );

    assign w_pc_inc = (r_pc == PC_W'(ROM_DEPTH - 1)) ? '0 : r_pc + 1'b1;

    always_comb begin
        w_op      = r_ir[OP_LSB +: OP_W];
        w_dst     = r_ir[DST_LSB +: FIELD_W];
        w_src1    = r_ir[SRC1_LSB +: FIELD_W];
        w_src0    = r_ir[SRC0_LSB +: FIELD_W];
        // Only the low nibble of a register field selects a register.
        w_dst_sel = w_dst[REG_SEL_W-1:0];
        w_s1_sel  = w_src1[REG_SEL_W-1:0];
        w_s0_sel  = w_src0[REG_SEL_W-1:0];
        w_a       = r_regs[w_s1_sel];
        w_b       = r_regs[w_s0_sel];
        w_we      = 1'b0;
        w_wdata   = '0;
        w_led_we  = 1'b0;
        w_take    = 1'b0;
        case (w_op)
            OP_LED: w_led_we = 1'b1;
            OP_STO: begin
                w_we    = 1'b1;
                w_wdata = DATA_W'({w_src1, w_src0});
            end
            OP_ADD: begin
                w_we    = 1'b1;
                w_wdata = w_a + w_b;
            end
            OP_SUB: begin
                w_we    = 1'b1;
                w_wdata = w_a - w_b;
            end
            OP_BLE: w_take = (w_a <= w_b);
            OP_JMP: w_take = 1'b1;
            default: ;
        endcase
    end

    // Fetch stage. A taken branch squashes the instruction fetched behind it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc  <= '0;
            r_ir  <= INSTR_NOP;
            r_led <= '0;
        end else begin
            if (w_take) begin
                r_ir <= INSTR_NOP;
                r_pc <= PC_W'(w_dst);
            end else begin
                r_ir <= w_rom_data;
                r_pc <= w_pc_inc;
            end
            if (w_led_we) begin
                r_led <= w_a[7:0];
            end
        end
    end

    // Register contents are deliberately left unreset; the write is only
    // suppressed while reset is asserted so an aborted program cannot commit.
    always_ff @(posedge Clock) begin
        if (!Reset && w_we) begin
            r_regs[w_dst_sel] <= w_wdata;
        end
    end

    assign oLed   = r_led;
    assign dbg.pc = r_pc;
    assign dbg.ir = r_ir;

endmodule

// File: tb/tb_mini_alu.sv
module tb_mini_alu;

    localparam int NP   = 6;
    localparam int MAXE = 300;
    localparam int PW   = 16 * 28;

    // Programs, word 0 in the least significant position.
    localparam logic [PW-1:0] P_DEF = {{10{28'h0}}, 28'h6030000, 28'h1000200,
        28'h3020201, 28'h2020000, 28'h2010001, 28'h0000000};
    localparam logic [PW-1:0] P_SUB = {{9{28'h0}}, 28'h6060000, 28'h1000400,
        28'h4040201, 28'h1000300, 28'h4030102, 28'h2020003, 28'h2010005};
    localparam logic [PW-1:0] P_BLT = {{4{28'h0}}, 28'h60B0000, 28'h1000700,
        {3{28'h0}}, 28'h6060000, 28'h1000500, 28'h50A0102, 28'h2070055,
        28'h20500AA, 28'h2020003, 28'h2010003};
    localparam logic [PW-1:0] P_BLN = {{4{28'h0}}, 28'h60B0000, 28'h1000700,
        {3{28'h0}}, 28'h6060000, 28'h1003500, 28'h50AF102, 28'h2070055,
        28'h20500AA, 28'h2020003, 28'h2010004};
    localparam logic [PW-1:0] P_ILL = {{2{28'h0}}, 28'h60D0000, 28'h1000200,
        28'h3020101, 28'hF010101, 28'hE010101, 28'hD010101, 28'hC010101,
        28'hB010101, 28'hA010101, 28'h9010101, 28'h8010101, 28'h7010101,
        28'h1000100, 28'h2010042};
    localparam logic [PW-1:0] P_WRP = {{12{28'h0}}, 28'h1000100, 28'h2010033,
        28'h1000100, 28'h2010021};

    logic        Clock = 1'b0;
    logic        Reset;
    logic [7:0]  led_obs [NP];
    logic [7:0]  pc_obs  [NP];
    logic [27:0] ir_obs  [NP];
    logic [7:0]  exp_led [NP][MAXE+1];
    int          k = 0;
    bit          chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    int          lit_p [21] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 3, 3, 4, 4, 4, 5, 5, 5, 5};
    int          lit_k [21] = '{5, 6, 9, 10, 14, 4, 5, 7, 6, 7, 8, 20, 7, 8, 3, 13, 14, 5, 258, 259, 261};
    logic [7:0]  lit_v [21] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00, 8'h02, 8'hFE,
                               8'h00, 8'h00, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'h42, 8'h42,
                               8'h84, 8'h33, 8'h33, 8'h21, 8'h33};

    always #5 Clock = ~Clock;

    mini_alu_if dbg0 ();
    mini_alu_if dbg1 ();
    mini_alu_if dbg2 ();
    mini_alu_if dbg3 ();
    mini_alu_if dbg4 ();
    mini_alu_if dbg5 ();

    mini_alu u_def (.Clock(Clock), .Reset(Reset), .oLed(led_obs[0]), .dbg(dbg0));
    mini_alu #(.USE_ALT_PROG(1'b1), .ALT_PROG(P_SUB))
        u_sub (.Clock(Clock), .Reset(Reset), .oLed(led_obs[1]), .dbg(dbg1));
    mini_alu #(.USE_ALT_PROG(1'b1), .ALT_PROG(P_BLT))
        u_blt (.Clock(Clock), .Reset(Reset), .oLed(led_obs[2]), .dbg(dbg2));
    mini_alu #(.USE_ALT_PROG(1'b1), .ALT_PROG(P_BLN))
        u_bln (.Clock(Clock), .Reset(Reset), .oLed(led_obs[3]), .dbg(dbg3));
    mini_alu #(.USE_ALT_PROG(1'b1), .ALT_PROG(P_ILL))
        u_ill (.Clock(Clock), .Reset(Reset), .oLed(led_obs[4]), .dbg(dbg4));
    mini_alu #(.USE_ALT_PROG(1'b1), .ALT_PROG(P_WRP))
        u_wrp (.Clock(Clock), .Reset(Reset), .oLed(led_obs[5]), .dbg(dbg5));

    assign pc_obs[0] = dbg0.pc;  assign ir_obs[0] = dbg0.ir;
    assign pc_obs[1] = dbg1.pc;  assign ir_obs[1] = dbg1.ir;
    assign pc_obs[2] = dbg2.pc;  assign ir_obs[2] = dbg2.ir;
    assign pc_obs[3] = dbg3.pc;  assign ir_obs[3] = dbg3.ir;
    assign pc_obs[4] = dbg4.pc;  assign ir_obs[4] = dbg4.ir;
    assign pc_obs[5] = dbg5.pc;  assign ir_obs[5] = dbg5.ir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Instruction-level interpreter: the instruction at the start address
    // executes at edge 2; each later one executes one edge after its
    // predecessor, two edges after a taken branch.
    task automatic build_model(input int p, input logic [PW-1:0] prog);
        logic [15:0] regs [16];
        logic [27:0] w;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  led;
        int          pc;
        int          next_exec;
        bit          taken;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        led = 8'h00;
        pc = 0;
        next_exec = 2;
        exp_led[p][0] = 8'h00;
        for (int e = 1; e <= MAXE; e++) begin
            if (e == next_exec) begin
                w = (pc < 16) ? prog[pc*28 +: 28] : 28'h0;
                a = regs[w[11:8]];
                b = regs[w[3:0]];
                taken = 1'b0;
                case (w[27:24])
                    4'd1: led = a[7:0];
                    4'd2: regs[w[19:16]] = w[15:0];
                    4'd3: regs[w[19:16]] = a + b;
                    4'd4: regs[w[19:16]] = a - b;
                    4'd5: taken = (a <= b);
                    4'd6: taken = 1'b1;
                    default: ;
                endcase
                if (taken) begin
                    pc = int'(w[23:16]);
                    next_exec = e + 2;
                end else begin
                    pc = (pc + 1) % 256;
                    next_exec = e + 1;
                end
            end
            exp_led[p][e] = led;
        end
    endtask

    task automatic reset_checks(input string tag);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s led[%0d]", tag, p), 32'(led_obs[p]), 32'h0);
            check($sformatf("%s pc[%0d]", tag, p), 32'(pc_obs[p]), 32'h0);
            check($sformatf("%s ir[%0d]", tag, p), 32'(ir_obs[p]), 32'h0);
        end
    endtask

    always @(posedge Clock) begin
        if (Reset) k <= 0;
        else       k <= k + 1;
    end

    always @(negedge Clock) begin
        if (chk_en && !Reset && k >= 1 && k <= MAXE) begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("led p%0d edge%0d", p, k), 32'(led_obs[p]), 32'(exp_led[p][k]));
            end
            for (int i = 0; i < 21; i++) begin
                if (lit_k[i] == k) begin
                    check($sformatf("lit dut p%0d edge%0d", lit_p[i], k),
                          32'(led_obs[lit_p[i]]), 32'(lit_v[i]));
                    check($sformatf("lit model p%0d edge%0d", lit_p[i], k),
                          32'(exp_led[lit_p[i]][k]), 32'(lit_v[i]));
                end
            end
            if (k == 11) begin
                check("ill pc edge11", 32'(pc_obs[4]), 32'd11);
                check("ill ir edge11", 32'(ir_obs[4]), 32'h0F010101);
            end
        end
    end

    initial begin
        build_model(0, P_DEF);
        build_model(1, P_SUB);
        build_model(2, P_BLT);
        build_model(3, P_BLN);
        build_model(4, P_ILL);
        build_model(5, P_WRP);
        Reset = 1'b1;
        repeat (5) begin
            @(posedge Clock);
            @(negedge Clock);
            reset_checks("rst5");
        end
        #1;
        chk_en = 1'b1;
        Reset = 1'b0;
        while (k < 15) @(negedge Clock);
        #1;
        check("led before midreset", 32'(led_obs[0]), 32'h03);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        reset_checks("rst1");
        #1;
        Reset = 1'b0;
        while (k < 280) @(negedge Clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
